// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the byte-stream program loader.
package prog_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHECK  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } state_t;

  // Bytes available from base to the top of a 2**aw byte space (33 bits so 2**32 fits).
  function automatic logic [32:0] capacity(input int unsigned aw, input int unsigned base);
    capacity = (33'd1 << aw) - {1'b0, base};
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream loader: LEN_LO, LEN_HI, payload, XOR checksum -> instruction memory byte writes.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BASE_ADDR     = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  output logic                     cpu_hold,
  output logic                     load_done,
  output logic                     load_err
);

  localparam int CMP_W = (LEN_W > ADDRESS_WIDTH + 1) ? LEN_W : ADDRESS_WIDTH + 1;
  localparam logic [CMP_W-1:0] CAP = CMP_W'(capacity(ADDRESS_WIDTH, BASE_ADDR));
  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDR);

  state_t                   state;
  logic [7:0]               len_lo;
  logic [LEN_W-1:0]         remaining;
  logic [ADDRESS_WIDTH-1:0] wr_ptr;
  logic [7:0]               csum;

  logic             accept;
  logic [LEN_W-1:0] len_full;
  logic [CMP_W-1:0] len_ext;

  // Status outputs are pure decodes of state, so reset clears them immediately.
  assign in_ready  = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) || (state == CHECK);
  assign cpu_hold  = (state != IDLE) && (state != DONE);
  assign load_done = (state == DONE);
  assign load_err  = (state == ERR);

  assign accept   = in_valid && in_ready;
  assign len_full = {in_data, len_lo};
  assign len_ext  = CMP_W'(len_full);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_lo    <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) state <= LEN_LO;
        end
        LEN_LO: begin
          if (accept) begin
            len_lo <= in_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (accept) begin
            // Cleared here too so an empty frame checks against 0x00.
            csum <= '0;
            if (len_ext > CAP) begin
              state <= ERR;
            end else if (len_full == '0) begin
              state <= CHECK;
            end else begin
              wr_ptr    <= BASE;
              remaining <= len_full;
              state     <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_addr  <= wr_ptr;
            mem_wdata <= in_data;
            csum      <= csum ^ in_data;
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (accept) state <= (in_data == csum) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: three instances cover default, offset base and small address space.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_prog_loader;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [2:0]      start = '0;
  logic [2:0]      in_valid = '0;
  logic [2:0][7:0] in_data = '0;
  logic [2:0]      in_ready, mem_we, cpu_hold, load_done, load_err;
  logic [2:0][7:0] mem_wdata;
  logic [15:0]     addr0, addr1;
  logic [7:0]      addr2;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct { int inst; int addr; int data; int cyc; } wr_t;
  wr_t wlog[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDRESS_WIDTH(16), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .mem_we(mem_we[0]), .mem_addr(addr0), .mem_wdata(mem_wdata[0]),
    .cpu_hold(cpu_hold[0]), .load_done(load_done[0]), .load_err(load_err[0]));

  prog_loader #(.ADDRESS_WIDTH(16), .BASE_ADDR('h100)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .mem_we(mem_we[1]), .mem_addr(addr1), .mem_wdata(mem_wdata[1]),
    .cpu_hold(cpu_hold[1]), .load_done(load_done[1]), .load_err(load_err[1]));

  prog_loader #(.ADDRESS_WIDTH(8), .BASE_ADDR('hFC)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .mem_we(mem_we[2]), .mem_addr(addr2), .mem_wdata(mem_wdata[2]),
    .cpu_hold(cpu_hold[2]), .load_done(load_done[2]), .load_err(load_err[2]));

  // Each posedge closes a cycle; log any write strobe that was high during it.
  always @(posedge clk) begin
    if (mem_we[0]) wlog.push_back('{0, int'(addr0), int'(mem_wdata[0]), cyc});
    if (mem_we[1]) wlog.push_back('{1, int'(addr1), int'(mem_wdata[1]), cyc});
    if (mem_we[2]) wlog.push_back('{2, int'(addr2), int'(mem_wdata[2]), cyc});
    cyc <= cyc + 1;
  end

  task automatic pulse_start(input int i);
    @(negedge clk);
    in_valid[i] = 1'b0;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // Presents b with optional idle gap; returns just after the accepting edge, valid left high.
  task automatic send(input int i, input logic [7:0] b, input int gap);
    int n;
    @(negedge clk);
    if (gap > 0) begin
      in_valid[i] = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data[i] = b;
    in_valid[i] = 1'b1;
    n = 0;
    while (!in_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 20) begin
      fails++;
      $error("FAIL accept_timeout: observed in_ready 0 expected 1 (inst %0d byte %0h)", i, b);
      in_valid[i] = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle(input int i);
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic send_frame(input int i, input logic [7:0] bytes[$], input int max_gap);
    foreach (bytes[k]) send(i, bytes[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    idle(i);
  endtask

  // n writes from instance i at base.. with data packed little-endian in d; consecutive if back2back.
  task automatic check_writes(input int i, input int base, input logic [31:0] d, input int n, input bit back2back);
    `CHK("write_count", wlog.size(), n)
    for (int k = 0; k < n && k < wlog.size(); k++) begin
      `CHK("write_inst", wlog[k].inst, i)
      `CHK("write_addr", wlog[k].addr, base + k)
      `CHK("write_data", wlog[k].data, int'(d[8*k +: 8]))
      if (back2back) `CHK("write_cycle", wlog[k].cyc, wlog[0].cyc + k)
    end
    wlog.delete();
  endtask

  task automatic check_status(input int i, input logic done, input logic err, input logic hold, input logic rdy);
    `CHK("load_done", load_done[i], done)
    `CHK("load_err", load_err[i], err)
    `CHK("cpu_hold", cpu_hold[i], hold)
    `CHK("in_ready", in_ready[i], rdy)
  endtask

  initial begin
    logic [31:0] word;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_status(i, 1'b0, 1'b0, 1'b0, 1'b0);
      `CHK("reset_we", mem_we[i], 1'b0)
      `CHK("reset_wdata", mem_wdata[i], 8'h00)
    end
    `CHK("reset_addr0", addr0, 16'h0000)
    `CHK("reset_addr2", addr2, 8'h00)
    rst_n = 1'b1;

    // Basic load, valid held high.
    pulse_start(0);
    check_status(0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(0, '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6}, 0);
    check_status(0, 1'b1, 1'b0, 1'b0, 1'b0);
    word = '0;
    foreach (wlog[k]) if (wlog[k].inst == 0 && wlog[k].addr < 4) word[8*wlog[k].addr +: 8] = 8'(wlog[k].data);
    `CHK("instr_pc0", word, 32'h00A00513)
    check_writes(0, 0, 32'h00A00513, 4, 1'b1);

    // Same frame with random gaps at base 0x100.
    pulse_start(1);
    send_frame(1, '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6}, 3);
    check_status(1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes(1, 'h100, 32'h00A00513, 4, 1'b0);

    // Bad checksum, then recovery with a good frame.
    pulse_start(0);
    send_frame(0, '{8'h02, 8'h00, 8'hAA, 8'h55, 8'h00}, 0);
    check_status(0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_writes(0, 0, 32'h000055AA, 2, 1'b1);
    pulse_start(0);
    send_frame(0, '{8'h01, 8'h00, 8'h7E, 8'h7E}, 0);
    check_status(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes(0, 0, 32'h0000007E, 1, 1'b1);

    // Empty frame.
    pulse_start(0);
    send_frame(0, '{8'h00, 8'h00, 8'h00}, 0);
    check_status(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes(0, 0, 32'h0, 0, 1'b0);

    // Oversize on the 8-bit instance: error right after LEN_HI.
    pulse_start(2);
    send(2, 8'h01, 0);
    send(2, 8'h01, 0);
    idle(2);
    check_status(2, 1'b0, 1'b1, 1'b1, 1'b0);
    check_writes(2, 'hFC, 32'h0, 0, 1'b0);

    // Exactly fills FC..FF; a start pulse mid-payload must be ignored.
    pulse_start(2);
    send(2, 8'h04, 0);
    send(2, 8'h00, 0);
    send(2, 8'h11, 0);
    send(2, 8'h22, 0);
    pulse_start(2);
    check_status(2, 1'b0, 1'b0, 1'b1, 1'b1);
    send(2, 8'h33, 0);
    send(2, 8'h44, 0);
    send(2, 8'h44, 0);
    idle(2);
    check_status(2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes(2, 'hFC, 32'h44332211, 4, 1'b0);

    // One byte past capacity.
    pulse_start(2);
    send_frame(2, '{8'h05, 8'h00}, 0);
    check_status(2, 1'b0, 1'b1, 1'b1, 1'b0);
    check_writes(2, 'hFC, 32'h0, 0, 1'b0);

    // Async reset after 2 of 4 payload bytes.
    pulse_start(0);
    send(0, 8'h04, 0);
    send(0, 8'h00, 0);
    send(0, 8'h13, 0);
    send(0, 8'h05, 0);
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check_status(0, 1'b0, 1'b0, 1'b0, 1'b0);
    `CHK("midrst_we", mem_we[0], 1'b0)
    `CHK("midrst_addr", addr0, 16'h0000)
    `CHK("midrst_wdata", mem_wdata[0], 8'h00)
    check_writes(0, 0, 32'h00000013, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start(0);
    send_frame(0, '{8'h04, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB6}, 0);
    check_status(0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_writes(0, 0, 32'h00A00513, 4, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`undef CHK
